// File: rtl/compute_core_pkg.sv
`default_nettype none
// ============================================================================
// compute_core_pkg : shared transfer types and helpers for the compute-core load path
// Revision 1.0
// ============================================================================
package compute_core_pkg;

   localparam int XFER_WIDTH_IN_BYTES = 64;
   localparam int XFER_BEATS_MAX      = 16;
   localparam int XFER_4K_WORDS       = 4096 / XFER_WIDTH_IN_BYTES;

   typedef logic [8*XFER_WIDTH_IN_BYTES-1:0] xfer_word_t;
   typedef logic [32:0]                      xfer_addr_t;
   typedef logic [31:0]                      xfer_len_t;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } reader_state_t;

   // Beats in the next burst: capped by max_burst, words left and the 4 KB boundary.
   function automatic logic [4:0] burst_len(input xfer_addr_t addr, input xfer_len_t remaining,
                                            input int max_burst);
      xfer_len_t lim;
      xfer_len_t to_4k;
      lim   = xfer_len_t'(max_burst);
      to_4k = xfer_len_t'(XFER_4K_WORDS) - xfer_len_t'(addr[11:6]);
      if (remaining < lim) lim = remaining;
      if (to_4k < lim) lim = to_4k;
      return lim[4:0];
   endfunction

endpackage
`default_nettype wire

// File: rtl/xfer_fifo.sv
`default_nettype none
// ============================================================================
// xfer_fifo : synchronous first-word-fall-through FIFO of xfer_word_t
// Revision 1.0
// ============================================================================
module xfer_fifo
   import compute_core_pkg::*;
#(
   parameter int DEPTH = 64
)(
   input  logic                     ap_clk,
   input  logic                     ap_rst_n,
   input  logic                     push,
   input  xfer_word_t               wr_data,
   input  logic                     pop,
   output xfer_word_t               rd_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   xfer_word_t    mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == CNT_FULL);
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign rd_data = mem[rd_ptr];

   // Storage is left unreset; only the pointers define what is valid.
   always_ff @(posedge ap_clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + (do_push ? (AW+1)'(1) : '0) - (do_pop ? (AW+1)'(1) : '0);
      end
   end

endmodule
`default_nettype wire

// File: rtl/hbm_burst_reader.sv
`default_nettype none
// ============================================================================
// hbm_burst_reader : fetches a contiguous HBM region in bursts and streams it out
// Revision 1.0
// ============================================================================
module hbm_burst_reader
   import compute_core_pkg::*;
#(
   parameter int FIFO_DEPTH = 64,
   parameter int MAX_BURST  = XFER_BEATS_MAX
)(
   input  logic        ap_clk,
   input  logic        ap_rst_n,
   input  logic        start,
   input  xfer_addr_t  base_addr,
   input  xfer_len_t   num_words,
   output logic        busy,
   output logic        done,
   output logic        ar_valid,
   input  logic        ar_ready,
   output xfer_addr_t  ar_addr,
   output logic [3:0]  ar_len,
   input  logic        r_valid,
   output logic        r_ready,
   input  xfer_word_t  r_data,
   input  logic        r_last,
   output logic        out_valid,
   input  logic        out_ready,
   output xfer_word_t  out_data,
   output logic        out_last
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;

   reader_state_t state;
   xfer_addr_t    addr;
   xfer_addr_t    start_addr;
   xfer_len_t     remaining_ar;
   xfer_len_t     remaining_out;
   logic [CW-1:0] credits;
   logic [CW-1:0] credits_nxt;
   logic [CW-1:0] fifo_count;
   logic [4:0]    start_blen;
   logic [4:0]    next_blen;
   logic [4:0]    ar_blen;
   logic          accept;
   logic          ar_hs;
   logic          out_hs;
   logic          push;
   logic          credit_ok;
   logic          fifo_full;
   logic          fifo_empty;
   xfer_word_t    fifo_head;

   assign start_addr  = {base_addr[32:6], 6'b0};
   assign start_blen  = burst_len(start_addr, num_words, MAX_BURST);
   assign next_blen   = burst_len(addr, remaining_ar, MAX_BURST);
   assign ar_blen     = {1'b0, ar_len} + 5'd1;
   assign accept      = (state == S_IDLE) && start;
   assign ar_hs       = ar_valid && ar_ready;
   assign out_hs      = out_valid && out_ready;
   assign credit_ok   = (32'(credits) + 32'(next_blen)) <= 32'(FIFO_DEPTH);
   assign credits_nxt = credits + (ar_hs ? CW'(ar_blen) : '0) - (out_hs ? CW'(1) : '0);

   assign r_ready   = busy;
   assign push      = r_valid && r_ready;
   assign out_valid = !fifo_empty;
   assign out_data  = fifo_empty ? '0 : fifo_head;
   assign out_last  = out_valid && (remaining_out == 32'd1);

   xfer_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .ap_clk   (ap_clk),
      .ap_rst_n (ap_rst_n),
      .push     (push),
      .wr_data  (r_data),
      .pop      (out_hs),
      .rd_data  (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count)
   );

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state         <= S_IDLE;
         busy          <= 1'b0;
         done          <= 1'b0;
         ar_valid      <= 1'b0;
         ar_addr       <= '0;
         ar_len        <= '0;
         addr          <= '0;
         remaining_ar  <= '0;
         remaining_out <= '0;
         credits       <= '0;
      end else begin
         done    <= 1'b0;
         credits <= credits_nxt;
         if (out_hs) remaining_out <= remaining_out - 32'd1;
         case (state)
            S_IDLE: begin
               if (start) begin
                  busy <= 1'b1;
                  if (num_words == '0) begin
                     state <= S_DONE;
                  end else begin
                     addr          <= start_addr;
                     remaining_ar  <= num_words;
                     remaining_out <= num_words;
                     ar_valid      <= 1'b1;
                     ar_addr       <= start_addr;
                     ar_len        <= 4'(start_blen - 5'd1);
                     state         <= S_ISSUE;
                  end
               end
            end
            // One idle cycle follows each handshake so the credit check sees settled counts.
            S_ISSUE: begin
               if (ar_valid) begin
                  if (ar_ready) begin
                     ar_valid     <= 1'b0;
                     addr         <= addr + 33'({ar_blen, 6'b0});
                     remaining_ar <= remaining_ar - 32'(ar_blen);
                     if (remaining_ar == 32'(ar_blen)) state <= S_DRAIN;
                  end
               end else if (credit_ok) begin
                  ar_valid <= 1'b1;
                  ar_addr  <= addr;
                  ar_len   <= 4'(next_blen - 5'd1);
               end
            end
            S_DRAIN: begin
               if (remaining_out == '0) state <= S_DONE;
            end
            S_DONE: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Response-side burst tracker, used only to cross-check r_last.
   xfer_addr_t rsp_addr;
   xfer_len_t  rsp_rem;
   logic [4:0] rsp_beat;
   logic [4:0] rsp_blen;
   logic       rsp_last;

   assign rsp_blen = burst_len(rsp_addr, rsp_rem, MAX_BURST);
   assign rsp_last = (rsp_beat + 5'd1) == rsp_blen;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         rsp_addr <= '0;
         rsp_rem  <= '0;
         rsp_beat <= '0;
      end else if (accept) begin
         rsp_addr <= start_addr;
         rsp_rem  <= num_words;
         rsp_beat <= '0;
      end else if (push) begin
         if (rsp_last) begin
            rsp_addr <= rsp_addr + 33'({rsp_blen, 6'b0});
            rsp_rem  <= rsp_rem - 32'(rsp_blen);
            rsp_beat <= '0;
         end else begin
            rsp_beat <= rsp_beat + 5'd1;
         end
      end
   end

   a_no_overflow: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
      !(r_valid && fifo_full));
   a_r_last: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
      push |-> (r_last == rsp_last));
   a_credits: assert property (@(posedge ap_clk) disable iff (!ap_rst_n)
      fifo_count <= credits);

endmodule
`default_nettype wire

// File: tb/tb_hbm_burst_reader.sv
`default_nettype none
// ============================================================================
// tb_hbm_burst_reader : scoreboard bench with an in-order burst memory model
// Revision 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_hbm_burst_reader;
   import compute_core_pkg::*;

   localparam int FIFO_DEPTH = 16;

   logic       ap_clk = 1'b0;
   logic       ap_rst_n = 1'b0;
   logic       start = 1'b0;
   xfer_addr_t base_addr = '0;
   xfer_len_t  num_words = '0;
   logic       busy, done, ar_valid, r_ready, out_valid, out_last;
   logic       ar_ready = 1'b1;
   xfer_addr_t ar_addr;
   logic [3:0] ar_len;
   logic       r_valid = 1'b0;
   xfer_word_t r_data = '0;
   logic       r_last = 1'b0;
   logic       out_ready = 1'b1;
   xfer_word_t out_data;

   hbm_burst_reader #(.FIFO_DEPTH(FIFO_DEPTH), .MAX_BURST(16)) dut (
      .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start), .base_addr(base_addr),
      .num_words(num_words), .busy(busy), .done(done), .ar_valid(ar_valid),
      .ar_ready(ar_ready), .ar_addr(ar_addr), .ar_len(ar_len), .r_valid(r_valid),
      .r_ready(r_ready), .r_data(r_data), .r_last(r_last), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
   );

   always #5 ap_clk = ~ap_clk;

   typedef struct packed { xfer_word_t data; logic last; } exp_word_t;
   typedef struct packed { xfer_addr_t addr; logic [3:0] len; } exp_ar_t;

   exp_word_t exp_q[$];
   exp_ar_t   exp_ar_q[$];
   exp_ar_t   pend[$];
   int errors = 0, checks = 0;
   int words_seen = 0, ar_seen = 0, r_beats = 0, done_seen = 0;
   bit rand_rvalid = 1'b0;

   function automatic xfer_word_t word_of(input xfer_addr_t a);
      xfer_word_t w;
      for (int i = 0; i < 16; i++) w[i*32 +: 32] = {a[32:6], 5'(i)} ^ 32'hC3A5_0000;
      return w;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge ap_clk);
      #1;
   endtask

   task automatic expect_cmd(input xfer_addr_t base, input int n);
      xfer_addr_t a;
      a = {base[32:6], 6'b0};
      for (int i = 0; i < n; i++) exp_q.push_back({word_of(a + 33'(i*64)), 1'(i == n-1)});
   endtask

   task automatic expect_ar(input xfer_addr_t a, input logic [3:0] l);
      exp_ar_q.push_back({a, l});
   endtask

   task automatic issue(input xfer_addr_t base, input int n);
      base_addr = base;
      num_words = n;
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic wait_done(input string name, input int budget);
      int d0, k;
      d0 = done_seen;
      k = 0;
      while (done_seen == d0 && k < budget) begin
         tick(1);
         k++;
      end
      checks++;
      if (done_seen == d0) begin
         errors++;
         $display("FAIL %s_done: no done within %0d cycles", name, budget);
      end
      check({name, "_words_left"}, 64'(exp_q.size()), 64'd0);
      check({name, "_ars_left"}, 64'(exp_ar_q.size()), 64'd0);
   endtask

   task automatic check_all_zero(input string name);
      check({name, "_ctrl"}, 64'({busy, done, ar_valid, r_ready, out_valid, out_last}), 64'd0);
      check({name, "_ar"}, 64'({ar_addr, ar_len}), 64'd0);
      check({name, "_out_data"}, 64'(|out_data), 64'd0);
   endtask

   // Scoreboard monitor: compares every handshake against the queues.
   initial begin
      exp_word_t e;
      exp_ar_t   ea;
      forever begin
         @(negedge ap_clk);
         if (ap_rst_n) begin
            if (out_valid && out_ready) begin
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("FAIL out_word: unexpected word %0h last %0b", out_data, out_last);
               end else begin
                  e = exp_q.pop_front();
                  if (out_data !== e.data || out_last !== e.last) begin
                     errors++;
                     $display("FAIL out_word[%0d]: got %0h last %0b required %0h last %0b",
                              words_seen, out_data, out_last, e.data, e.last);
                  end
               end
               words_seen++;
            end
            if (ar_valid && ar_ready) begin
               checks++;
               if (exp_ar_q.size() == 0) begin
                  errors++;
                  $display("FAIL ar: unexpected burst addr %0h len %0d", ar_addr, ar_len);
               end else begin
                  ea = exp_ar_q.pop_front();
                  if (ar_addr !== ea.addr || ar_len !== ea.len) begin
                     errors++;
                     $display("FAIL ar[%0d]: got addr %0h len %0d required addr %0h len %0d",
                              ar_seen, ar_addr, ar_len, ea.addr, ea.len);
                  end
               end
               ar_seen++;
            end
            if (done) done_seen++;
         end
      end
   end

   // In-order memory model; data depends only on the word address.
   initial begin
      int beat;
      beat = 0;
      forever begin
         @(posedge ap_clk);
         #1;
         if (!ap_rst_n) begin
            pend.delete();
            beat = 0;
            r_valid = 1'b0;
            r_last = 1'b0;
         end else if (pend.size() > 0 && (!rand_rvalid || $urandom_range(0, 1) == 1)) begin
            r_valid = 1'b1;
            r_data = word_of(pend[0].addr + 33'(beat*64));
            r_last = (beat == int'(pend[0].len));
         end else begin
            r_valid = 1'b0;
            r_last = 1'b0;
         end
         @(negedge ap_clk);
         if (ap_rst_n) begin
            if (r_valid && r_ready) begin
               r_beats++;
               if (r_last) begin
                  void'(pend.pop_front());
                  beat = 0;
               end else begin
                  beat++;
               end
            end
            if (ar_valid && ar_ready) pend.push_back({ar_addr, ar_len});
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int a0, r0, w0, k;
      tick(3);
      check_all_zero("reset");
      ap_rst_n = 1'b1;
      tick(2);

      // 40 words from 0: two full bursts and a tail
      expect_cmd(33'h0, 40);
      expect_ar(33'h000, 4'd15);
      expect_ar(33'h400, 4'd15);
      expect_ar(33'h800, 4'd7);
      issue(33'h0, 40);
      check("first_ar_valid", 64'(ar_valid), 64'd1);
      check("busy_after_start", 64'(busy), 64'd1);
      wait_done("linear40", 800);

      // 4 KB boundary split, low address bits ignored
      expect_cmd(33'hFDF, 4);
      expect_ar(33'hFC0, 4'd0);
      expect_ar(33'h1000, 4'd2);
      issue(33'hFDF, 4);
      wait_done("boundary", 200);

      // zero-length command
      issue(33'h123456, 0);
      check("zero_done_early", 64'({done, busy}), 64'b01);
      tick(1);
      check("zero_done_pulse", 64'({done, busy, ar_valid, out_valid}), 64'b1000);
      tick(1);
      check("zero_done_cleared", 64'(done), 64'd0);

      // back-pressure: credits cap issue at one burst
      out_ready = 1'b0;
      expect_cmd(33'h0, 48);
      expect_ar(33'h000, 4'd15);
      expect_ar(33'h400, 4'd15);
      expect_ar(33'h800, 4'd15);
      a0 = ar_seen;
      r0 = r_beats;
      issue(33'h0, 48);
      tick(40);
      check("bp_ar_count", 64'(ar_seen - a0), 64'd1);
      check("bp_beats", 64'(r_beats - r0), 64'd16);
      check("bp_no_ar_valid", 64'(ar_valid), 64'd0);
      check("bp_out_valid", 64'(out_valid), 64'd1);
      out_ready = 1'b1;
      wait_done("backpressure", 800);

      // ar_ready stall with random r_valid gaps
      ar_ready = 1'b0;
      rand_rvalid = 1'b1;
      expect_cmd(33'h2040, 20);
      expect_ar(33'h2040, 4'd15);
      expect_ar(33'h2440, 4'd3);
      issue(33'h2040, 20);
      for (int i = 0; i < 5; i++) begin
         check("stall_ar", 64'({ar_valid, ar_addr, ar_len}), {27'd0, 1'b1, 33'h2040, 4'd15});
         tick(1);
      end
      ar_ready = 1'b1;
      wait_done("stall", 800);
      rand_rvalid = 1'b0;

      // asynchronous reset after word 10 of 40, then a fresh command
      expect_cmd(33'h0, 40);
      expect_ar(33'h000, 4'd15);
      expect_ar(33'h400, 4'd15);
      expect_ar(33'h800, 4'd7);
      w0 = words_seen;
      issue(33'h0, 40);
      k = 0;
      while (words_seen - w0 < 10 && k < 300) begin
         tick(1);
         k++;
      end
      check("rst_reached_word10", 64'(words_seen - w0 >= 10), 64'd1);
      #1;
      ap_rst_n = 1'b0;
      #1;
      check_all_zero("midrst");
      exp_q.delete();
      exp_ar_q.delete();
      tick(2);
      ap_rst_n = 1'b1;
      tick(2);
      expect_cmd(33'h10000, 8);
      expect_ar(33'h10000, 4'd7);
      issue(33'h10000, 8);
      wait_done("after_reset", 200);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hbm_burst_reader.md
Name: hbm_burst_reader

Overview:
- Read-side load stage directly upstream of the compute core.
- Fetches a contiguous region of one HBM pseudo-channel as bursts of 512-bit words on an AXI4-style read-address/read-data pair.
- Buffers returned words and streams them to the compute core over a valid/ready interface, marking the final word.
- Used once per CC_INIT/CC_EXEC phase to load operand vectors.

Parameters:
- FIFO_DEPTH, 64, words of read-data buffering; power of two, at least 16.
- MAX_BURST, 16, maximum beats per burst; at most 16 because ar_len is 4 bits.

Ports:
- ap_clk  in  1  clock
- ap_rst_n  in  1  reset, asynchronous assert, active-low
- start  in  1  one-cycle command strobe; accepted only in S_IDLE
- base_addr  in  33  byte address of the first word; bits [5:0] ignored (treated as 0)
- num_words  in  32  number of 64-byte words to read
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse after the last word is handed downstream
- ar_valid  out  1  read-address valid
- ar_ready  in  1  read-address ready
- ar_addr  out  33  burst start byte address
- ar_len  out  4  beats minus one
- r_valid  in  1  read-data valid
- r_ready  out  1  read-data ready
- r_data  in  512  read-data word
- r_last  in  1  last beat of burst; checked only by assertion
- out_valid  out  1  stream valid to compute core
- out_ready  in  1  stream ready
- out_data  out  512  stream word
- out_last  out  1  high with the final word of the command

Behaviour:
- Reset: on async assertion of ap_rst_n, all outputs go to 0 and the FIFO, counters and state clear. This applies mid-operation too: in-flight responses are discarded, and the environment must also reset the memory side.
- States:
  - S_IDLE:
    - start with num_words == 0 → S_DONE.
    - start with num_words > 0 → latch addr = {base_addr[32:6], 6'b0} and remaining_ar = remaining_out = num_words; go to S_ISSUE.
    - start in any other state is ignored.
  - S_ISSUE:
    - Burst length blen = min(MAX_BURST, remaining_ar, 64 − addr[11:6]). Bursts never cross a 4 KB boundary.
    - ar_valid is asserted only when credits + blen ≤ FIFO_DEPTH.
    - ar_addr/ar_len are registered and stay stable while ar_valid && !ar_ready. ar_valid is never withdrawn before the handshake.
    - On handshake: addr += blen*64, remaining_ar −= blen, credits += blen.
    - remaining_ar reaching 0 → S_DRAIN.
  - S_DRAIN:
    - Wait for remaining_out == 0 → S_DONE.
  - S_DONE:
    - Pulse done for one cycle, drop busy, return to S_IDLE.
    - start may be accepted in the cycle after done.
- Timing:
  - First ar_valid appears the cycle after start.
  - With out_ready held high, a word entering the FIFO appears on out_data the following cycle.
- Credits:
  - credits counts words reserved in the FIFO, i.e. outstanding plus buffered. Width is clog2(FIFO_DEPTH)+1.
  - Decrements by 1 on each out handshake.
  - An AR handshake and an out handshake in the same cycle net to +blen−1.
- Read data: r_ready = busy. Overflow cannot occur by construction; an assertion fires if r_valid && FIFO full.
- Output stream:
  - out_valid = FIFO not empty. out_data = FIFO head, stable while out_valid && !out_ready.
  - out_last = out_valid && remaining_out == 1.
  - remaining_out decrements on each out handshake.
- Address wrap: addr arithmetic is modulo 2^33. Crossing a pseudo-channel boundary is the caller's responsibility and is not checked.
- Ordering: responses are assumed in-order, single ID.

Decomposition:
- Shared package compute_core_pkg gains:
  - XFER_BEATS_MAX = 16
  - XFER_4K_WORDS = 4096/XFER_WIDTH_IN_BYTES
  - reader state enum {S_IDLE, S_ISSUE, S_DRAIN, S_DONE}
- Reuse xfer_word_t, xfer_addr_t and xfer_len_t from the package for ports.
- One sub-module: xfer_fifo.
  - Synchronous FIFO of xfer_word_t, depth FIFO_DEPTH.
  - Ports: push, pop, full, empty, count.
  - Same clock/reset convention as this block.

Test Plan:
- base_addr=0x0, num_words=40, ar_ready/out_ready held 1 → ARs (0x000, len 15), (0x400, len 15), (0x800, len 7). 40 words out in order, out_last on word 40, then done pulse.
- base_addr=0xFC0, num_words=4 → two bursts (0xFC0, len 0) and (0x1000, len 2). No burst crosses 4 KB.
- num_words=0 → no ar_valid, done pulses 2 cycles after start, out_valid stays 0.
- FIFO_DEPTH=16, num_words=48, out_ready held 0 → exactly one AR (len 15) is issued. 16 words are buffered, and no further AR until out_ready rises. Then all 48 words arrive intact.
- ar_ready stalled 5 cycles and r_valid toggled randomly → ar_addr/ar_len stable during the stall. Output matches the memory model word-for-word.
- ap_rst_n pulsed low mid-transfer at word 10 of 40 → all outputs 0 immediately. A new start with num_words=8 then completes normally with 8 words.
